// File: rtl/md_pkg.sv
// Shared types, constants and arithmetic helpers for the iterative RV32M
// multiply/divide unit.
package md_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } md_state_e;

    // Quotient returned for division by zero (all ones).
    localparam logic [MD_XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    // Quotient returned for the most-negative / -1 overflow.
    localparam logic [MD_XLEN-1:0] DIV_OVF_QUO  = 32'h8000_0000;

    // Is rs1 interpreted as two's complement for this op?
    function automatic logic op_a_signed(input md_op_e op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    // Is rs2 interpreted as two's complement for this op?
    function automatic logic op_b_signed(input md_op_e op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

    // Magnitude of a word; unsigned operands pass through untouched.
    function automatic logic [MD_XLEN-1:0] abs_w(input logic [MD_XLEN-1:0] x,
                                                  input logic is_signed);
        logic [MD_XLEN-1:0] r;
        if (is_signed && x[MD_XLEN-1]) begin
            r = ~x + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Conditional two's-complement negate of a word.
    function automatic logic [MD_XLEN-1:0] neg_w(input logic [MD_XLEN-1:0] x,
                                                  input logic neg);
        logic [MD_XLEN-1:0] r;
        if (neg) begin
            r = ~x + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Conditional two's-complement negate of a double word (full product).
    function automatic logic [2*MD_XLEN-1:0] neg_dw(input logic [2*MD_XLEN-1:0] x,
                                                     input logic neg);
        logic [2*MD_XLEN-1:0] r;
        if (neg) begin
            r = ~x + 64'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, sign fixed up on completion.
// Division special cases are resolved at accept and bypass the iteration.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);

    md_state_e             state_r, state_next_s;
    md_op_e                op_r, op_in_s;
    logic [CNT_W-1:0]      cnt_r;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*XLEN-1:0]     acc_r, acc_next_s;
    logic [XLEN-1:0]       dsr_r;          // multiplicand or divisor magnitude
    logic                  neg_a_r, neg_b_r;
    logic [4:0]            rd_pend_r;
    logic                  busy_r, done_r, we_r;
    logic [XLEN-1:0]       result_r;
    logic [4:0]            rd_out_r;

    logic                  a_sgn_s, b_sgn_s;
    logic [XLEN-1:0]       a_mag_s, b_mag_s;
    logic                  special_s;
    logic [XLEN-1:0]       special_val_s;
    logic                  last_s;
    logic [XLEN:0]         mul_sum_s;
    logic [XLEN:0]         div_sh_s;
    logic [XLEN+1:0]       div_diff_s;
    logic [2*XLEN-1:0]     prod_s;
    logic [XLEN-1:0]       final_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;
    assign we_out = we_r;

    // Decode the incoming request: operand magnitudes and division shortcuts.
    always_comb begin
        op_in_s       = md_op_e'(funct3);
        a_sgn_s       = op_a_signed(op_in_s);
        b_sgn_s       = op_b_signed(op_in_s);
        a_mag_s       = abs_w(op_a, a_sgn_s);
        b_mag_s       = abs_w(op_b, b_sgn_s);
        special_s     = 1'b0;
        special_val_s = {XLEN{1'b0}};
        if (funct3[2]) begin
            if (op_b == {XLEN{1'b0}}) begin
                special_s     = 1'b1;
                special_val_s = funct3[1] ? op_a : DIV_ZERO_QUO;
            end else if (a_sgn_s && (op_a == DIV_OVF_QUO) && (op_b == {XLEN{1'b1}})) begin
                special_s     = 1'b1;
                special_val_s = funct3[1] ? {XLEN{1'b0}} : DIV_OVF_QUO;
            end else begin
                special_s     = 1'b0;
            end
        end else begin
            special_s = 1'b0;
        end
    end

    // One iteration step of the shift-add multiplier or restoring divider.
    always_comb begin
        last_s     = (state_r == CALC) && (cnt_r == CNT_W'(XLEN-1));
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                     (acc_r[0] ? {1'b0, dsr_r} : {(XLEN+1){1'b0}});
        div_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s = {1'b0, div_sh_s} - {2'b00, dsr_r};
        if (op_r[2]) begin
            if (div_diff_s[XLEN+1]) begin
                acc_next_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and word selection applied to the final iteration result.
    always_comb begin
        prod_s  = neg_dw(acc_next_s, neg_a_r ^ neg_b_r);
        final_s = {XLEN{1'b0}};
        if (op_r[2]) begin
            if (op_r[1]) begin
                final_s = neg_w(acc_next_s[2*XLEN-1:XLEN], neg_a_r);
            end else begin
                final_s = neg_w(acc_next_s[XLEN-1:0], neg_a_r ^ neg_b_r);
            end
        end else begin
            if (op_r == OP_MUL) begin
                final_s = prod_s[XLEN-1:0];
            end else begin
                final_s = prod_s[2*XLEN-1:XLEN];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = special_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r      <= OP_MUL;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            dsr_r     <= {XLEN{1'b0}};
            neg_a_r   <= 1'b0;
            neg_b_r   <= 1'b0;
            rd_pend_r <= 5'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            we_r      <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            rd_out_r  <= 5'd0;
        end else begin
            done_r <= 1'b0;
            we_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= op_in_s;
                        rd_pend_r <= rd_in;
                        neg_a_r   <= a_sgn_s & op_a[XLEN-1];
                        neg_b_r   <= b_sgn_s & op_b[XLEN-1];
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        if (funct3[2]) begin
                            acc_r <= {{XLEN{1'b0}}, a_mag_s};
                            dsr_r <= b_mag_s;
                        end else begin
                            acc_r <= {{XLEN{1'b0}}, b_mag_s};
                            dsr_r <= a_mag_s;
                        end
                        if (special_s) begin
                            result_r <= special_val_s;
                            rd_out_r <= rd_in;
                            done_r   <= 1'b1;
                            we_r     <= (rd_in != 5'd0);
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        result_r <= final_s;
                        rd_out_r <= rd_pend_r;
                        done_r   <= 1'b1;
                        we_r     <= (rd_pend_r != 5'd0);
                    end
                end
                DONE:    busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file:
  - op_a and op_b are driven by the register file read data (RD1, RD2).
  - result, rd_out and we_out drive the register-file write port (WD3, AD3, WE3) through the writeback mux.
- Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (from RD1)
- op_b  input  XLEN  rs2 value (from RD2)
- rd_in  input  5  destination register
- busy  output  1  high while an op is in flight (CALC or DONE)
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  result; held until next accepted start
- rd_out  output  5  destination, captured at start
- we_out  output  1  done && (rd_out != 0); drives WE3

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset wins over every other input.
- Reset values: state IDLE, busy 0, done 0, we_out 0, result 0, rd_out 0, counter 0.
- FSM states and transitions:
  - IDLE -> CALC on start, normal case.
  - IDLE -> DONE on start, special division case.
  - CALC -> DONE when the counter reaches XLEN-1.
  - DONE -> IDLE unconditionally.
- Accept (edge where start=1 in IDLE) captures:
  - funct3 and rd_in;
  - magnitudes of op_a/op_b (two's-complement abs where the operand is signed for this op);
  - result sign flags.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Multiply:
  - Unsigned shift-add, one multiplier bit per CALC cycle, 2*XLEN accumulator.
  - Product negated at DONE entry if sign flags differ.
  - MUL returns the low word; MULH* return the high word.
- Divide:
  - Restoring, one quotient bit per CALC cycle.
  - Quotient negated if the signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases are decided at accept and skip CALC; result is loaded directly:
  - op_b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
  - The multiply ops have no special cases.
- Latency, with the accept edge as cycle 0:
  - Normal ops: CALC in cycles 1..32; done=1 in cycle 33.
  - Special cases: done=1 in cycle 1.
- busy rises in cycle 1 and falls in the cycle after done.
- done and we_out are single-cycle pulses, registered outputs.
- result and rd_out update in the done cycle and hold until the next accept.
- start while busy is ignored, with no queueing. start in the DONE cycle is ignored too. The earliest re-accept is the cycle after done.
- Operand inputs are don't-care after accept.
- rst mid-operation aborts the op: no done, no we_out, outputs return to reset values. The next start is accepted normally.
- rd_in==0: the op completes and done pulses, but we_out stays 0 (x0 is never written).

Decomposition:
- Package md_pkg holds:
  - enum md_op_e, encoding the funct3 values above;
  - enum md_state_e {IDLE, CALC, DONE};
  - constants for the div-by-zero quotient and the overflow quotient.
- Single module; no sub-module needed. Abs/negate helpers are functions in md_pkg.

Test Plan:
1. MUL, op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> done in cycle 33, result 0xFFFFFFEB, rd_out=5, we_out=1 for one cycle; busy=1 in cycles 1..33.
2. op_a=op_b=0xFFFFFFFF:
   - MULHU -> 0xFFFFFFFE;
   - MULH -> 0x00000000;
   - MULHSU -> 0xFFFFFFFF;
   - MUL -> 0x00000001.
3. op_a=0xFFFFFFF9, op_b=2:
   - DIV -> 0xFFFFFFFD;
   - REM -> 0xFFFFFFFF;
   - DIVU -> 0x7FFFFFFC;
   - REMU -> 1.
4. Special cases, each with done in cycle 1:
   - DIV 5/0 -> 0xFFFFFFFF;
   - REMU 5/0 -> 5;
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
   - REM of the same -> 0.
5. Busy and x0 handling:
   - start MUL 3*4 rd=7, then start DIV in cycles 5 and 33 -> both ignored; done in cycle 33 with result 12, rd_out 7.
   - Separate op with rd_in=0 -> done=1, we_out=0.
6. Reset and recovery:
   - rst=1 in cycle 10 of a DIV -> busy=0 and result=0 in cycle 11; no done pulse within 40 cycles.
   - Subsequent MUL 2*3 -> result 6 in cycle 33 of the new op.
